mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameters: none; data width fixed at 16, iteration count fixed at 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_opcode  input  4  ALU opcode requested by the pipeline EX stage.
REQ-005 ex_operandA  input  16  EX-stage operand A.
REQ-006 ex_operandB  input  16  EX-stage operand B.
REQ-007 mul_start  input  1  request an unsigned 16x16 multiply; sampled only in IDLE.
REQ-008 mul_a  input  16  multiplicand, captured with mul_start.
REQ-009 mul_b  input  16  multiplier, captured with mul_start.
REQ-010 ALUo  input  16  result from the shared ALU.
REQ-011 flags  input  3  ALU flags {NF,ZF,CF}; only CF (bit 0) is used.
REQ-012 alu_opcode  output  4  opcode driven to the shared ALU.
REQ-013 alu_operandA  output  16  operand A driven to the shared ALU.
REQ-014 alu_operandB  output  16  operand B driven to the shared ALU.
REQ-015 mul_busy  output  1  high while the sequencer owns the ALU; the pipeline stalls on it.
REQ-016 mul_done  output  1  one-cycle pulse when the product is valid.
REQ-017 mul_hi  output  16  product bits 31:16.
REQ-018 mul_lo  output  16  product bits 15:0.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE, held in a registered state variable.
REQ-020 In IDLE and DONE, alu_opcode/operandA/operandB SHALL combinationally equal ex_opcode/ex_operandA/ex_operandB.
REQ-021 In IDLE with mul_start=1 at an edge, the block SHALL capture:
  - mcand <= mul_a
  - lo <= mul_b
  - hi <= 0
  - count <= 0
  - state <= RUN
REQ-022 In RUN, the ALU drive SHALL be:
  - alu_opcode = A_ADD
  - alu_operandA = hi
  - alu_operandB = lo[0] ? mcand : 16'h0000
REQ-023 On each RUN edge, the block SHALL update:
  - hi <= {flags[0], ALUo[15:1]}
  - lo <= {ALUo[0], lo[15:1]}
  - count <= count+1
REQ-024 RUN SHALL transition to DONE on the edge where count==15, giving exactly 16 RUN cycles.
REQ-025 DONE SHALL last one cycle, then return to IDLE unconditionally.
REQ-026 mul_start SHALL be ignored in RUN and DONE; requests are not queued.
REQ-027 Timing for mul_start sampled at edge 0:
  - mul_busy=1 exactly during cycles 1..16
  - mul_done=1 in cycle 17 only
  - next start sampled no earlier than the cycle-18 edge
REQ-028 mul_busy SHALL be decoded from the state register only (state==RUN), glitch-free.
REQ-029 mul_hi/mul_lo SHALL equal {hi,lo}, be valid from the mul_done cycle, and hold until the next accepted mul_start.
REQ-030 The product SHALL be exact unsigned 32-bit mul_a*mul_b with no overflow; ZF and NF SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately force:
  - state=IDLE
  - hi, lo, mcand = 0
  - count = 0
  - mul_busy = 0, mul_done = 0
  - ALU ports revert to EX pass-through
REQ-032 Reset during RUN SHALL abort the operation with no mul_done pulse; the first start after release behaves as from cold.

Structure
REQ-033 ALU opcode constants (A_ADD etc.) SHALL come from the shared header; the FSM state encodings SHALL be local constants.
REQ-034 No sub-module is required; the ALU stays external, and mul_seq contains only the FSM, the counter, the datapath registers and the port mux.

Verification
REQ-035 mul_a=16'hFFFF, mul_b=16'hFFFF -> mul_hi=16'hFFFE, mul_lo=16'h0001; mul_done exactly 17 cycles after the start edge.
REQ-036 mul_a=3, mul_b=5 -> {mul_hi,mul_lo}=32'h0000000F; mul_a=0, mul_b=16'h1234 -> 32'h00000000.
REQ-037 IDLE with ex_opcode=A_SUB, ex_operandA=5, ex_operandB=3 -> ALU ports pass these through unchanged; during RUN alu_opcode=A_ADD regardless of ex_opcode.
REQ-038 rst_n pulsed low in RUN cycle 8 -> state=IDLE, mul_busy=0, outputs 0, no mul_done; a following 3*5 start -> 15.
REQ-039 mul_start held high continuously with changing operands -> one product every 18 cycles; operands presented during RUN/DONE not captured.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Opcodes shared by the pipeline ALU and its clients.
package mul_seq_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ITER_N  = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FLAGS_W = 3;

  typedef enum logic [OP_W-1:0] {
    A_ADD  = 4'h0,
    A_SUB  = 4'h1,
    A_AND  = 4'h2,
    A_OR   = 4'h3,
    A_XOR  = 4'h4,
    A_NOT  = 4'h5,
    A_SHL  = 4'h6,
    A_SHR  = 4'h7,
    A_PASS = 4'h8
  } alu_op_e;

  // Index of the carry bit inside the {NF,ZF,CF} flag vector.
  localparam int unsigned FLAG_CF = 0;

endpackage : mul_seq_pkg

// File: rtl/mul_seq.sv
// Sequential 16x16 unsigned shift-add multiplier that borrows the pipeline ALU
// for its additions and hands the ALU back to the EX stage when idle.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      ex_opcode,
  input  logic [DATA_W-1:0]    ex_operandA,
  input  logic [DATA_W-1:0]    ex_operandB,
  input  logic                 mul_start,
  input  logic [DATA_W-1:0]    mul_a,
  input  logic [DATA_W-1:0]    mul_b,
  input  logic [DATA_W-1:0]    ALUo,
  input  logic [FLAGS_W-1:0]   flags,
  output logic [OP_W-1:0]      alu_opcode,
  output logic [DATA_W-1:0]    alu_operandA,
  output logic [DATA_W-1:0]    alu_operandB,
  output logic                 mul_busy,
  output logic                 mul_done,
  output logic [DATA_W-1:0]    mul_hi,
  output logic [DATA_W-1:0]    mul_lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'(ITER_N - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, hi_q, lo_q;
  logic [3:0]        count_q;

  // NF and ZF are meaningless for the accumulate step; only the carry matters.
  logic unused_flags;
  assign unused_flags = ^flags[2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_RUN;
      S_RUN:   if (count_q == LAST_ITER) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_opcode   = ex_opcode;
    alu_operandA = ex_operandA;
    alu_operandB = ex_operandB;
    mul_busy     = 1'b0;
    mul_done     = 1'b0;
    case (state_q)
      S_RUN: begin
        alu_opcode   = A_ADD;
        alu_operandA = hi_q;
        alu_operandB = lo_q[0] ? mcand_q : '0;
        mul_busy     = 1'b1;
      end
      S_DONE:  mul_done = 1'b1;
      default: ;
    endcase
  end

  // Each RUN cycle shifts the 17-bit partial sum {CF,ALUo} right into {hi,lo}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else if (state_q == S_IDLE && mul_start) begin
      mcand_q <= mul_a;
      lo_q    <= mul_b;
      hi_q    <= '0;
      count_q <= '0;
    end else if (state_q == S_RUN) begin
      hi_q    <= {flags[FLAG_CF], ALUo[DATA_W-1:1]};
      lo_q    <= {ALUo[0], lo_q[DATA_W-1:1]};
      count_q <= count_q + 4'd1;
    end
  end

  assign mul_hi = hi_q;
  assign mul_lo = lo_q;

endmodule : mul_seq
